// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - RV32I load/store unit: lane alignment, byte enables, load extension, timed memory handshake
// Optional define MAU_MISALIGN_TRAP_EN: misaligned half/word accesses trap (code 01) instead of being aligned down.
module mem_access_unit #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        rsp_valid,
   output logic [31:0] rdata,
   output logic        err,
   output logic [1:0]  err_code,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state_q, state_d;
   logic        req_ready_q, req_ready_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic [1:0]  err_code_q, err_code_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [3:0]  mem_be_q, mem_be_d;
   logic [15:0] wait_cnt_q, wait_cnt_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [1:0]  off_q, off_d;
   logic        write_q, write_d;

   logic        illegal, misaligned, is_half, is_word;
   logic [1:0]  off_acc;
   logic [3:0]  be_acc;
   logic [31:0] wdata_acc;
   logic [31:0] lane, load_ext;

   // Decode of the request presented on the input side, used only at accept.
   always_comb begin
      is_half    = (funct3[1:0] == 2'b01);
      is_word    = (funct3[1:0] == 2'b10);
      illegal    = req_write ? (funct3 > 3'b010)
                             : ((funct3 == 3'b011) || (funct3[2:1] == 2'b11));
      misaligned = 1'b0;
      off_acc    = addr[1:0];
`ifdef MAU_MISALIGN_TRAP_EN
      misaligned = (is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00));
`else
      if (is_half) begin
         off_acc = {addr[1], 1'b0};
      end else if (is_word) begin
         off_acc = 2'b00;
      end
`endif
      case (funct3[1:0])
         2'b00: begin
            be_acc    = 4'b0001 << off_acc;
            wdata_acc = {4{wdata[7:0]}};
         end
         2'b01: begin
            be_acc    = off_acc[1] ? 4'b1100 : 4'b0011;
            wdata_acc = {2{wdata[15:0]}};
         end
         default: begin
            be_acc    = 4'b1111;
            wdata_acc = wdata;
         end
      endcase
   end

   always_comb begin
      lane = mem_rdata >> {off_q, 3'b000};
      case (funct3_q)
         3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
         3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
         3'b100:  load_ext = {24'd0, lane[7:0]};
         3'b101:  load_ext = {16'd0, lane[15:0]};
         default: load_ext = lane;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      req_ready_d = req_ready_q;
      rsp_valid_d = 1'b0;
      rdata_d     = rdata_q;
      err_d       = err_q;
      err_code_d  = err_code_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_be_d    = mem_be_q;
      wait_cnt_d  = wait_cnt_q;
      funct3_d    = funct3_q;
      off_d       = off_q;
      write_d     = write_q;
      case (state_q)
         IDLE: begin
            if (req_valid && req_ready_q) begin
               funct3_d    = funct3;
               write_d     = req_write;
               off_d       = off_acc;
               wait_cnt_d  = 16'd0;
               req_ready_d = 1'b0;
               if (illegal || misaligned) begin
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
                  err_d       = 1'b1;
                  err_code_d  = illegal ? 2'b11 : 2'b01;
                  rdata_d     = 32'd0;
               end else begin
                  state_d     = WAIT;
                  mem_req_d   = 1'b1;
                  mem_we_d    = req_write;
                  mem_addr_d  = {addr[31:2], 2'b00};
                  mem_wdata_d = wdata_acc;
                  mem_be_d    = be_acc;
               end
            end
         end
         WAIT: begin
            // An ack arriving in the timeout cycle still completes normally.
            if (mem_ack) begin
               state_d     = RESP;
               mem_req_d   = 1'b0;
               rsp_valid_d = 1'b1;
               err_d       = 1'b0;
               err_code_d  = 2'b00;
               rdata_d     = write_q ? 32'd0 : load_ext;
            end else if (wait_cnt_q == 16'(TIMEOUT - 1)) begin
               state_d     = RESP;
               mem_req_d   = 1'b0;
               rsp_valid_d = 1'b1;
               err_d       = 1'b1;
               err_code_d  = 2'b10;
               rdata_d     = 32'd0;
            end else begin
               wait_cnt_d = wait_cnt_q + 16'd1;
            end
         end
         RESP: begin
            state_d     = IDLE;
            req_ready_d = 1'b1;
         end
         default: begin
            state_d     = IDLE;
            req_ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rdata_q     <= 32'd0;
         err_q       <= 1'b0;
         err_code_q  <= 2'b00;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'd0;
         mem_wdata_q <= 32'd0;
         mem_be_q    <= 4'b0000;
         wait_cnt_q  <= 16'd0;
         funct3_q    <= 3'b000;
         off_q       <= 2'b00;
         write_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         err_code_q  <= err_code_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_be_q    <= mem_be_d;
         wait_cnt_q  <= wait_cnt_d;
         funct3_q    <= funct3_d;
         off_q       <= off_d;
         write_q     <= write_d;
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rdata     = rdata_q;
   assign err       = err_q;
   assign err_code  = err_code_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_be    = mem_be_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit (honours MAU_MISALIGN_TRAP_EN)
module tb_mem_access_unit;
   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_write;
   logic [2:0]  funct3;
   logic [31:0] addr, wdata;
   logic        rsp_valid, err;
   logic [31:0] rdata;
   logic [1:0]  err_code;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;

   int n_vec  = 0;
   int n_miss = 0;

   typedef struct packed {
      logic        mem;
      logic        we;
      logic [3:0]  be;
      logic [31:0] waddr;
      logic [31:0] wdata;
      logic        err;
      logic [1:0]  code;
      logic [31:0] rdata;
   } exp_t;

   exp_t sb_q[$];

   mem_access_unit #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .funct3(funct3), .addr(addr), .wdata(wdata),
      .rsp_valid(rsp_valid), .rdata(rdata), .err(err), .err_code(err_code),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: byte-by-byte view of the access.
   function automatic exp_t model(input logic w, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [31:0] word, input int k);
      exp_t e;
      int   nbytes, off;
      logic legal;
      e = '0;
      legal = w ? (f3 <= 3'd2) : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      if (!legal) begin
         e.err = 1'b1; e.code = 2'b11;
         return e;
      end
      nbytes = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      off = int'(a[1:0]);
`ifdef MAU_MISALIGN_TRAP_EN
      if (off % nbytes != 0) begin
         e.err = 1'b1; e.code = 2'b01;
         return e;
      end
`else
      off = off - (off % nbytes);
`endif
      e.mem   = 1'b1;
      e.we    = w;
      e.waddr = {a[31:2], 2'b00};
      for (int b = 0; b < 4; b++) begin
         e.be[b] = (b >= off) && (b < off + nbytes);
         e.wdata[8*b +: 8] = wd[8*(b % nbytes) +: 8];
      end
      if (k == 0) begin
         e.err = 1'b1; e.code = 2'b10;
      end else if (!w) begin
         for (int b = 0; b < 4; b++)
            e.rdata[8*b +: 8] = (b < nbytes) ? word[8*(off+b) +: 8]
                                             : {8{~f3[2] & word[8*(off+nbytes)-1]}};
      end
      return e;
   endfunction

   always @(negedge clk) begin
      if (rsp_valid) begin
         if (sb_q.size() == 0) begin
            check("rsp_unexpected", 32'(rsp_valid), 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("rsp_err", 32'(err), 32'(e.err));
            check("rsp_code", 32'(err_code), 32'(e.code));
            check("rsp_rdata", rdata, e.rdata);
         end
      end
   end

   task automatic wait_ready();
      int g = 0;
      while (!req_ready && g < 50) begin
         step();
         g++;
      end
      if (!req_ready) check("ready_timeout", 32'(req_ready), 32'd1);
   endtask

   // RESP cycle: also pokes stray req_valid/mem_ack that must be ignored.
   task automatic resp_cycle(input string tag);
      req_valid = 1'b1; funct3 = 3'b111; mem_ack = 1'b1;
      @(negedge clk);
      check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, "_req_low"}, 32'(mem_req), 32'd0);
      step();
      req_valid = 1'b0; mem_ack = 1'b0;
   endtask

   // k = cycle after accept in which mem_ack is driven; 0 = never.
   task automatic run(input string tag, input logic w, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] word, input int k);
      exp_t e;
      int   lim;
      e = model(w, f3, a, wd, word, k);
      wait_ready();
      sb_q.push_back(e);
      req_valid = 1'b1; req_write = w; funct3 = f3; addr = a; wdata = wd;
      step();
      req_valid = 1'b0;
      if (e.mem) begin
         lim = (k == 0) ? TO : k;
         for (int i = 1; i <= lim; i++) begin
            req_valid = 1'b1; funct3 = 3'b111; addr = $urandom;
            mem_ack   = (i == k);
            mem_rdata = (i == k) ? word : $urandom;
            @(negedge clk);
            check({tag, "_mem_req"}, 32'(mem_req), 32'd1);
            check({tag, "_mem_be"}, 32'(mem_be), 32'(e.be));
            if (i == 1) begin
               check({tag, "_mem_we"}, 32'(mem_we), 32'(e.we));
               check({tag, "_mem_addr"}, mem_addr, e.waddr);
               check({tag, "_mem_wdata"}, mem_wdata, e.wdata);
            end
            step();
            mem_ack = 1'b0; req_valid = 1'b0;
         end
      end
      resp_cycle(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; funct3 = 3'b000;
      addr = 32'd0; wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
      repeat (3) step();
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_err_code", 32'(err_code), 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_mem_be", 32'(mem_be), 32'd0);
      step();
      rst = 1'b0;
      step();

      run("lw",      1'b0, 3'b010, 32'h0000_0100, 32'd0,         32'hDEAD_BEEF, 1);
      run("lb",      1'b0, 3'b000, 32'h0000_0103, 32'd0,         32'h80FF_FFFF, 1);
      run("lbu",     1'b0, 3'b100, 32'h0000_0103, 32'd0,         32'h80FF_FFFF, 2);
      run("sh",      1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'hFFFF_FFFF, 1);
      run("sb",      1'b1, 3'b000, 32'h0000_0401, 32'h0000_0055, 32'h0,        3);
      run("sw",      1'b1, 3'b010, 32'h0000_0508, 32'hCAFE_F00D, 32'h0,        1);
      run("lh",      1'b0, 3'b001, 32'h0000_0600, 32'd0,         32'h1234_8001, 1);
      run("lhu",     1'b0, 3'b101, 32'h0000_0602, 32'd0,         32'h8001_1234, 2);
      run("tmo",     1'b0, 3'b010, 32'h0000_0700, 32'd0,         32'h0,        0);
      run("ack_tmo", 1'b0, 3'b010, 32'h0000_0704, 32'd0,         32'h1111_2222, TO);
      run("lw_mis",  1'b0, 3'b010, 32'h0000_0101, 32'd0,         32'h5A5A_A5A5, 1);
      run("lh_mis",  1'b0, 3'b001, 32'h0000_0103, 32'd0,         32'hF00F_7FFE, 1);
      run("f3_011",  1'b0, 3'b011, 32'h0000_0100, 32'd0,         32'h0,        1);
      run("sw_f3_4", 1'b1, 3'b100, 32'h0000_0100, 32'hFFFF_FFFF, 32'h0,        1);

      for (int n = 0; n < 8; n++) begin
         logic [2:0] f3r;
         logic       wr;
         wr  = 1'($urandom_range(0, 1));
         f3r = wr ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5));
         run("rnd", wr, f3r, $urandom & 32'h000F_FFFF, $urandom, $urandom, $urandom_range(1, 3));
      end

      // Reset during the second WAIT cycle drops the access without a response.
      wait_ready();
      req_valid = 1'b1; req_write = 1'b0; funct3 = 3'b010; addr = 32'h0000_0300;
      step();
      req_valid = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      check("rstw_mem_req", 32'(mem_req), 32'd0);
      check("rstw_req_ready", 32'(req_ready), 32'd1);
      check("rstw_rsp_valid", 32'(rsp_valid), 32'd0);
      repeat (2) step();
      run("lw_after_rst", 1'b0, 3'b010, 32'h0000_0100, 32'd0, 32'h0BAD_F00D, 1);

      repeat (3) step();
      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
